// File: rtl/sha2_msg_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sha2_msg_sched
// Sequential SHA-256 message-schedule generator. Takes the 16 message words of
// one 512-bit block and streams out W[0..63] in order, one word per cycle,
// using a 16-word sliding window and the small sigma functions.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   flush_i      synchronous abort of the current block (beats all handshakes)
//   in_valid_i   in_word_i carries a message word
//   in_ready_o   message word is accepted this cycle
//   in_word_i    message word, W0 first
//   out_valid_o  out_word_o / out_idx_o are valid
//   out_ready_i  consumer takes the output word this cycle
//   out_word_o   schedule word W[out_idx_o]
//   out_idx_o    schedule index 0..63
//   out_last_o   valid word with index 63
//   busy_o       expanding, or an output word is pending
// -----------------------------------------------------------------------------
module sha2_msg_sched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_word_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_word_o,
    output logic [5:0]  out_idx_o,
    output logic        out_last_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // sig0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sig1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    state_e            state_q, state_d;
    logic [5:0]        t_q, t_d;
    // win_q[0] = W[t-16] ... win_q[15] = W[t-1]; new words enter at the top.
    logic [15:0][31:0] win_q, win_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [5:0]        out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              free_s;
    logic [31:0]       w_new_s;

    assign free_s  = !out_valid_q || out_ready_i;
    assign w_new_s = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    // Reset and flush both suppress acceptance combinationally so that no
    // word is taken in a cycle whose progress is about to be discarded.
    assign in_ready_o  = rst_ni && !flush_i && (state_q == ST_LOAD) && free_s;
    assign out_valid_o = out_valid_q;
    assign out_word_o  = out_word_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == ST_EXPAND) || out_valid_q;

    // Next-state logic: load/expand sequencing, window shift, output register.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            t_d         = 6'd0;
            state_d     = ST_LOAD;
        end else if (free_s) begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid_i) begin
                        out_valid_d = 1'b1;
                        out_word_d  = in_word_i;
                        out_idx_d   = t_q;
                        win_d       = {in_word_i, win_q[15:1]};
                        t_d         = t_q + 6'd1;
                        if (t_q == 6'd15) begin
                            state_d = ST_EXPAND;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        // Previous word (if any) was consumed; nothing new.
                        out_valid_d = 1'b0;
                    end
                end
                ST_EXPAND: begin
                    out_valid_d = 1'b1;
                    out_word_d  = w_new_s;
                    out_idx_d   = t_q;
                    win_d       = {w_new_s, win_q[15:1]};
                    if (t_q == 6'd63) begin
                        t_d     = 6'd0;
                        state_d = ST_LOAD;
                    end else begin
                        t_d     = t_q + 6'd1;
                        state_d = ST_EXPAND;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    t_d         = 6'd0;
                    state_d     = ST_LOAD;
                end
            endcase
        end else begin
            // Stalled by the consumer: everything holds.
            out_valid_d = out_valid_q;
        end
        out_last_d = out_valid_d && (out_idx_d == 6'd63);
    end

    // State, window and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_LOAD;
            t_q         <= 6'd0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'd0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: doc/sha2_msg_sched.md
# sha2_msg_sched

Sequential SHA-256 message-schedule generator for the crypto datapath. Accepts the 16 32-bit words of one 512-bit message block and emits the full W[0..63] schedule in order, one word per cycle. It computes the expansion with the small sigma functions sig0 and sig1 and modulo-2^32 addition. It drives the core's round logic through a valid/ready stream and runs independently of the combinational SHA-2 instruction unit.

## Interface
- No parameters; word width fixed at 32 and schedule length fixed at 64.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  synchronous abort of the current block; priority over all handshakes.
- in_valid_i  in  1  in_word_i is valid.
- in_ready_o  out  1  block accepts in_word_i this cycle.
- in_word_i  in  32  message word, big-endian word order W0 first.
- out_valid_o  out  1  out_word_o/out_idx_o valid.
- out_ready_i  in  1  consumer takes the output word this cycle.
- out_word_o  out  32  schedule word W[out_idx_o].
- out_idx_o  out  6  schedule index t, 0..63.
- out_last_o  out  1  out_valid_o and out_idx_o == 63.
- busy_o  out  1  state == EXPAND or out_valid_o.

## Operation
- sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x); all sums truncated to 32 bits.
- Window: 16 x 32 shift register; win[0] = W[t-16] … win[15] = W[t-1]. Each produced word shifts in at win[15].
- Expansion: W[t] = sig1(win[14]) + win[9] + sig0(win[1]) + win[0].
- Counter t (6 bits) = index of next word to produce.
- Output register is free when !out_valid_o || out_ready_i.
- States:
  - LOAD (reset state). in_ready_o = free. On in_valid_i && in_ready_o: the output register takes {in_word_i, t}, the window shifts, and t++. After accepting t = 15, go to EXPAND.
  - EXPAND. in_ready_o = 0. When free, the output register takes {W[t], t}, the window shifts, and t++. After producing t = 63, set t = 0 and go to LOAD.
- No word is ever dropped or duplicated. While out_valid_o && !out_ready_i, out_word_o and out_idx_o hold stable, and t and the window hold.
- flush_i = 1: out_valid_o = 0, t = 0, state = LOAD. The window is not cleared because it is fully rewritten before use. in_ready_o is forced to 0 during that cycle.
- Reset: out_valid_o = 0, out_word_o = 0, out_idx_o = 0, out_last_o = 0, busy_o = 0, in_ready_o = 0 during reset and 1 the cycle after. State = LOAD, t = 0, window = 0. Reset mid-block discards all progress.

## Timing
- Latency: a word accepted or produced in cycle c is on out_word_o in cycle c+1.
- Throughput: 1 word per cycle with out_ready_i held high.
- One block: first input accepted in cycle c, W15 valid at c+16, W16 at c+17, W63 at c+64.
- Back-to-back blocks: the cycle W63 is consumed (out_ready_i = 1), state is already LOAD and free = 1, so the next block's W0 can be accepted that same cycle. Sustained rate is 64 cycles per block.
- in_ready_o depends combinationally on out_ready_i. There is no combinational path from in_valid_i to any output.
- Input gaps (in_valid_i low) during LOAD stall t, with no effect on correctness.

## Test plan
- "abc" padded block: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, out_ready_i = 1 -> outputs idx 0..63 on consecutive cycles; W16 = 0x61626380, W17 = 0x000F0000, all 64 words match the golden model; out_last_o only with idx 63.
- All-zero block -> 64 words of 0x00000000; in_ready_o low for exactly 48 cycles during EXPAND.
- Backpressure: out_ready_i = 0 for 5 cycles while idx = 20 is valid -> out_word_o and out_idx_o stable, in_ready_o = 0; on release, idx 21 appears next cycle with the correct value.
- Random in_valid_i gaps and random out_ready_i toggling over 10 random blocks sent back-to-back -> sequence exactly matches the model; the next W0 is accepted in the same cycle W63 is consumed.
- flush_i asserted at idx 30 -> out_valid_o = 0 next cycle, in_ready_o = 1 the cycle after; a fresh block then yields correct W0..W63 with idx restarting at 0.
- rst_ni low for one cycle at idx 40 -> all outputs at reset values; the following block is correct from idx 0.
